sd_blk_responder: RTL and testbench
===================================

# sd_blk_responder

Target side of the hps_io sector interface (`sd_lba`, `sd_rd`, `sd_wr`, `sd_ack`, `sd_buff_*`). It serves 512-byte sector reads and writes from a core-side initiator, such as the backup-RAM save/load sequencer, against a word-addressed backing memory. This allows save-state and backup-RAM logic to be simulated and exercised without the HPS. It replaces the HPS end of the link in benches and in standalone builds.

## Interface
Parameters:
- `MEM_AW`, default 24: backing-memory word-address width.
- `SECTORS`, default 64: image size in sectors (four slots of 16).

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `sd_lba` in 32: sector number, sampled at request accept.
- `sd_rd` in 1: read request, level.
- `sd_wr` in 1: write request, level.
- `sd_ack` out 1: transfer in progress.
- `sd_buff_addr` out 8: word index within the sector.
- `sd_buff_dout` out 16: read data to the initiator.
- `sd_buff_wr` out 1: one-cycle strobe qualifying `sd_buff_dout`/`sd_buff_addr`.
- `sd_buff_din` in 16: write data from the initiator's buffer RAM.
- `mem_addr` out MEM_AW: word address, `{lba, word}` truncated to MEM_AW.
- `mem_rd` out 1: memory read request, held until `mem_ready`.
- `mem_wr` out 1: memory write request, held until `mem_ready`.
- `mem_wdata` out 16: write data.
- `mem_rdata` in 16: read data, valid with `mem_ready` on a read.
- `mem_ready` in 1: completes the current access.
- `err` out 1: sticky out-of-range flag (see Configuration).

## Operation
FSM states: IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_CAP, WR_REQ, DONE.
- IDLE: when `sd_rd | sd_wr`, latch `sd_lba`, clear the word counter, assert `sd_ack`. `sd_rd` wins if both are high. Go to RD_REQ for a read, WR_ADDR for a write. Requests are sampled only in IDLE.
- Initiator contract: it drops `sd_rd`/`sd_wr` on the rising edge of `sd_ack`. The responder does not depend on this.
- Read path:
  - RD_REQ: hold `mem_rd` with `mem_addr = {lba, cnt}` until `mem_ready`, then capture `mem_rdata`.
  - RD_PUT: drive `sd_buff_addr = cnt` and `sd_buff_dout`, pulse `sd_buff_wr` for one cycle.
  - If cnt = 255, go to DONE; otherwise increment cnt and return to RD_REQ.
- Write path:
  - WR_ADDR: drive `sd_buff_addr = cnt`.
  - WR_CAP: hold the address and capture `sd_buff_din`. This covers one cycle of buffer-RAM read latency.
  - WR_REQ: hold `mem_wr` with `mem_wdata` until `mem_ready`.
  - If cnt = 255, go to DONE; otherwise increment cnt and return to WR_ADDR.
- DONE: deassert `sd_ack`, return to IDLE.
- Counter: 8-bit; 255 is terminal, with no wrap into the next sector.
- LBA: the full 32-bit value is latched. `mem_addr` takes the low bits only.

## Timing
- Reset values: `sd_ack`=0, `sd_buff_wr`=0, `sd_buff_addr`=0, `sd_buff_dout`=0, `mem_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, `err`=0, state IDLE.
- Accept latency: `sd_ack` rises one cycle after the request is first seen high in IDLE.
- Read with zero-wait memory: 2 cycles per word (RD_REQ, RD_PUT). The first `sd_buff_wr` comes 2 cycles after `sd_ack` rises.
- Write with zero-wait memory: 3 cycles per word.
- Memory waits stretch RD_REQ/WR_REQ one cycle per wait cycle. No timeout.
- `sd_ack` stays low for at least one cycle (DONE to IDLE) between sectors. A request already high in that IDLE cycle is accepted immediately.
- Reset mid-transfer: all outputs take their reset values in the same cycle. The pending memory access is abandoned.

## Configuration
- Macro `SD_BLK_RESP_RANGE_CHECK_EN`, when defined: a request with `lba >= SECTORS`
  - reads 256 zero words with no `mem_rd`;
  - discards writes with no `mem_wr`, keeping full handshake timing;
  - sets `err`, which clears only on reset.
- Not defined: no check; the address wraps modulo 2^MEM_AW and `err` is tied to 0.

## Structure
- Package `sd_blk_resp_pkg`:
  - state enum;
  - `SECTOR_WORDS = 256`;
  - `CNT_W = 8`.
- Single module; no sub-module. The FSM and counter are small enough to live together.

## Test plan
- Read, zero-wait memory: memory holds word = addr ^ 16'hA5A5; read lba 5 → 256 `sd_buff_wr` pulses, addr 0..255, data = {5,addr}^A5A5, `sd_ack` high 513 cycles.
- Write: initiator RAM holds 16'h1000 + i; write lba 3 → `mem_wr` at addresses 0x300..0x3FF with data 0x1000..0x10FF.
- Chained save: initiator issues lba 0x20..0x2F, re-raising `sd_wr` on each falling `sd_ack` → 16 sectors, no lost request, one idle cycle between sectors.
- Memory stall: `mem_ready` low 3 cycles on word 7 → `sd_buff_wr` for word 7 delayed exactly 3 cycles; data intact.
- Reset at word 100 of a read → `sd_ack`, `mem_rd`, `sd_buff_wr` low immediately; the next read of lba 0 completes normally.
- With the macro defined: read lba 64 → 256 zero words, no `mem_rd`, `err`=1. Without the macro, same read → memory addresses 0x4000..0x40FF, `err`=0.

Source files
------------

// File: rtl/sd_blk_responder_pkg.sv
// Shared constants and state encoding for the sd_blk_responder sector target.
package sd_blk_resp_pkg;

  localparam int unsigned SECTOR_WORDS = 256;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned ST_W         = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SECTOR_WORDS - 1);

  // State encodings; the RTL switches on these constants.
  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_RD_REQ  = 3'd1;
  localparam logic [ST_W-1:0] ST_RD_PUT  = 3'd2;
  localparam logic [ST_W-1:0] ST_WR_ADDR = 3'd3;
  localparam logic [ST_W-1:0] ST_WR_CAP  = 3'd4;
  localparam logic [ST_W-1:0] ST_WR_REQ  = 3'd5;
  localparam logic [ST_W-1:0] ST_DONE    = 3'd6;

  // Same encoding as an enum, for waveform decode and debug casts.
  typedef enum logic [ST_W-1:0] {
    S_IDLE    = ST_IDLE,
    S_RD_REQ  = ST_RD_REQ,
    S_RD_PUT  = ST_RD_PUT,
    S_WR_ADDR = ST_WR_ADDR,
    S_WR_CAP  = ST_WR_CAP,
    S_WR_REQ  = ST_WR_REQ,
    S_DONE    = ST_DONE
  } state_e;

endpackage

// File: rtl/sd_blk_responder_if.sv
// hps_io-style sector link: master is the core-side initiator, slave is the responder.
interface sd_blk_responder_if;
  import sd_blk_resp_pkg::*;

  logic [31:0]      sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic             sd_ack;
  logic [CNT_W-1:0] sd_buff_addr;
  logic [15:0]      sd_buff_dout;
  logic             sd_buff_wr;
  logic [15:0]      sd_buff_din;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface

// File: rtl/sd_blk_responder.sv
// Sector target for the hps_io sd_* link, serving 512-byte reads/writes from a
// word-addressed backing memory. Optional feature: define SD_BLK_RESP_RANGE_CHECK_EN
// to suppress memory traffic for lba >= SECTORS and raise a sticky err.
module sd_blk_responder
  import sd_blk_resp_pkg::*;
#(
  parameter int unsigned MEM_AW  = 24,
  parameter int unsigned SECTORS = 64
) (
  input  logic                clk_sys,
  input  logic                reset,
  sd_blk_responder_if.slave   sd,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [15:0]         mem_wdata,
  input  logic [15:0]         mem_rdata,
  input  logic                mem_ready,
  output logic                err
);

`ifdef SD_BLK_RESP_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic [ST_W-1:0]   state_q, state_d;
  logic [31:0]       lba_q, lba_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              oor_q, oor_d;
  logic              ack_q, ack_d;
  logic [CNT_W-1:0]  buff_addr_q, buff_addr_d;
  logic [15:0]       buff_dout_q, buff_dout_d;
  logic              buff_wr_q, buff_wr_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_inc_c;

  // Memory word address is {lba, word} truncated to the memory width.
  function automatic logic [MEM_AW-1:0] word_addr(input logic [31:0] lba,
                                                  input logic [CNT_W-1:0] w);
    return MEM_AW'({lba, w});
  endfunction

  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    lba_d       = lba_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    oor_d       = oor_q;
    ack_d       = ack_q;
    buff_addr_d = buff_addr_q;
    buff_dout_d = buff_dout_q;
    buff_wr_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (sd.sd_rd | sd.sd_wr) begin
          lba_d      = sd.sd_lba;
          cnt_d      = '0;
          ack_d      = 1'b1;
          oor_d      = RANGE_CHECK && (sd.sd_lba >= 32'(SECTORS));
          err_d      = err_q | oor_d;
          mem_addr_d = word_addr(sd.sd_lba, '0);
          if (sd.sd_rd) begin
            state_d  = ST_RD_REQ;
            mem_rd_d = !oor_d;
          end else begin
            state_d     = ST_WR_ADDR;
            buff_addr_d = '0;
          end
        end
      end

      ST_RD_REQ: begin
        if (oor_q) begin
          rdata_d = '0;
          state_d = ST_RD_PUT;
        end else if (mem_ready) begin
          rdata_d  = mem_rdata;
          mem_rd_d = 1'b0;
          state_d  = ST_RD_PUT;
        end
      end

      ST_RD_PUT: begin
        buff_addr_d = cnt_q;
        buff_dout_d = rdata_q;
        buff_wr_d   = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d      = cnt_inc_c;
          mem_addr_d = word_addr(lba_q, cnt_inc_c);
          mem_rd_d   = !oor_q;
          state_d    = ST_RD_REQ;
        end
      end

      ST_WR_ADDR: begin
        state_d = ST_WR_CAP;
      end

      ST_WR_CAP: begin
        mem_wdata_d = sd.sd_buff_din;
        mem_addr_d  = word_addr(lba_q, cnt_q);
        mem_wr_d    = !oor_q;
        state_d     = ST_WR_REQ;
      end

      ST_WR_REQ: begin
        if (oor_q || mem_ready) begin
          mem_wr_d = 1'b0;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d       = cnt_inc_c;
            buff_addr_d = cnt_inc_c;
            state_d     = ST_WR_ADDR;
          end
        end
      end

      ST_DONE: begin
        ack_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        ack_d    = 1'b0;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any pending access.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lba_q       <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      oor_q       <= 1'b0;
      ack_q       <= 1'b0;
      buff_addr_q <= '0;
      buff_dout_q <= '0;
      buff_wr_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lba_q       <= lba_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      oor_q       <= oor_d;
      ack_q       <= ack_d;
      buff_addr_q <= buff_addr_d;
      buff_dout_q <= buff_dout_d;
      buff_wr_q   <= buff_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign sd.sd_ack       = ack_q;
  assign sd.sd_buff_addr = buff_addr_q;
  assign sd.sd_buff_dout = buff_dout_q;
  assign sd.sd_buff_wr   = buff_wr_q;
  assign mem_addr        = mem_addr_q;
  assign mem_rd          = mem_rd_q;
  assign mem_wr          = mem_wr_q;
  assign mem_wdata       = mem_wdata_q;
  assign err             = err_q;

endmodule

// File: tb/tb_sd_blk_responder.sv
// Self-checking bench for sd_blk_responder: directed test-plan cases plus a
// randomized read/write mix checked against a sector-level memory model.
`timescale 1ns/1ps
module tb_sd_blk_responder;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  sd_blk_responder_if sd_if();

  logic [23:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        err;

  sd_blk_responder #(.MEM_AW(24), .SECTORS(64)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .sd        (sd_if),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .err       (err)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  int ack_rise = 0;
  logic ack_prev = 1'b0;

  logic [15:0] buf_ram [256];
  logic [15:0] mem_store [int];
  logic [15:0] ref_mem [int];

  int wait_left = 0;
  int stall_used = 0;
  int stall_arm = 0;
  logic [23:0] stall_addr = 24'hFFFFFF;
  bit rand_wait = 1'b0;

  int rd_a[$], rd_d[$], rd_c[$];
  int wr_a[$], wr_d[$];
  int mr_a[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_peek(input logic [23:0] a);
    if (mem_store.exists(int'(a))) return mem_store[int'(a)];
    return a[15:0] ^ 16'hA5A5;
  endfunction

  function automatic int word_key(input logic [31:0] lba, input int i);
    logic [23:0] k;
    k = 24'((lba << 8) | 32'(i));
    return int'(k);
  endfunction

  // Reference memory: initial content addr^A5A5, overwritten sector by sector.
  function automatic logic [15:0] ref_rd(input logic [31:0] lba, input int i);
    int key;
    key = word_key(lba, i);
    if (ref_mem.exists(key)) return ref_mem[key];
    return 16'(key) ^ 16'hA5A5;
  endfunction

  task automatic ref_write(input logic [31:0] lba);
    for (int i = 0; i < 256; i++) ref_mem[word_key(lba, i)] = buf_ram[i];
  endtask

  // Backing memory response, evaluated mid-cycle.
  always @(negedge clk_sys) begin
    mem_rdata = mem_peek(mem_addr);
    mem_ready = (mem_rd | mem_wr) && (wait_left == 0) &&
                !(mem_addr == stall_addr && stall_used < stall_arm);
  end

  // Memory bookkeeping, initiator buffer RAM and output monitor.
  always @(posedge clk_sys) begin
    if (!rand_wait) wait_left = 0;
    if (!reset && (mem_rd || mem_wr)) begin
      if (!mem_ready) begin
        if (mem_addr == stall_addr && stall_used < stall_arm) stall_used++;
        else if (wait_left > 0) wait_left--;
      end else begin
        if (mem_wr) begin
          mem_store[int'(mem_addr)] = mem_wdata;
          wr_a.push_back(int'(mem_addr));
          wr_d.push_back(int'(mem_wdata));
        end else begin
          mr_a.push_back(int'(mem_addr));
        end
        wait_left = rand_wait ? int'($urandom_range(0, 2)) : 0;
      end
    end
    if (sd_if.sd_buff_wr) begin
      rd_a.push_back(int'(sd_if.sd_buff_addr));
      rd_d.push_back(int'(sd_if.sd_buff_dout));
      rd_c.push_back(cyc);
    end
    if (sd_if.sd_ack && !ack_prev) ack_rise = cyc;
    ack_prev = sd_if.sd_ack;
    sd_if.sd_buff_din <= buf_ram[sd_if.sd_buff_addr];
    cyc++;
  end

  // Raise a request now (caller is at a negedge); returns at the negedge where ack is low again.
  task automatic xfer(input bit is_wr, input logic [31:0] lba, output int acc_lat, output int ack_cyc);
    acc_lat = 0;
    ack_cyc = 0;
    sd_if.sd_lba = lba;
    sd_if.sd_rd  = !is_wr;
    sd_if.sd_wr  = is_wr;
    while (!sd_if.sd_ack && acc_lat < 8) begin
      @(negedge clk_sys);
      acc_lat++;
    end
    sd_if.sd_rd = 1'b0;
    sd_if.sd_wr = 1'b0;
    if (!sd_if.sd_ack) begin
      chk("ack_rise", sd_if.sd_ack, 1);
      return;
    end
    while (sd_if.sd_ack && ack_cyc < 20000) begin
      ack_cyc++;
      @(negedge clk_sys);
    end
    if (sd_if.sd_ack) chk("ack_fall", sd_if.sd_ack, 0);
  endtask

  task automatic check_read(input logic [31:0] lba, input int base);
    int n;
    n = rd_a.size() - base;
    chk("rd_count", n, 256);
    for (int i = 0; i < ((n < 256) ? n : 256); i++) begin
      chk("rd_addr", rd_a[base + i], i);
      chk("rd_data", rd_d[base + i], ref_rd(lba, i));
    end
  endtask

  task automatic check_write(input logic [31:0] lba, input int base);
    int n;
    n = wr_a.size() - base;
    chk("wr_count", n, 256);
    for (int i = 0; i < ((n < 256) ? n : 256); i++) begin
      chk("wr_addr", wr_a[base + i], word_key(lba, i));
      chk("wr_data", wr_d[base + i], buf_ram[i]);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, ackc, rb, wb, mb, n, waitc;
    bit is_wr;
    logic [31:0] lba;

    sd_if.sd_lba = '0;
    sd_if.sd_rd  = 1'b0;
    sd_if.sd_wr  = 1'b0;
    for (int i = 0; i < 256; i++) buf_ram[i] = 16'h0;

    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("rst_ack", sd_if.sd_ack, 0);
    chk("rst_buff_wr", sd_if.sd_buff_wr, 0);
    chk("rst_buff_addr", sd_if.sd_buff_addr, 0);
    chk("rst_buff_dout", sd_if.sd_buff_dout, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Zero-wait read of lba 5.
    rb = rd_a.size();
    xfer(1'b0, 32'd5, lat, ackc);
    chk("rd_acc_lat", lat, 1);
    chk("rd_ack_cycles", ackc, 513);
    chk("first_wr_lat", (rd_c.size() > rb) ? rd_c[rb] - ack_rise : -1, 2);
    check_read(32'd5, rb);

    // Write lba 3 with buffer = 0x1000 + i, then read it back.
    for (int i = 0; i < 256; i++) buf_ram[i] = 16'h1000 + 16'(i);
    @(negedge clk_sys);
    wb = wr_a.size();
    xfer(1'b1, 32'd3, lat, ackc);
    chk("wr_acc_lat", lat, 1);
    chk("wr_ack_cycles", ackc, 769);
    check_write(32'd3, wb);
    ref_write(32'd3);
    @(negedge clk_sys);
    rb = rd_a.size();
    xfer(1'b0, 32'd3, lat, ackc);
    check_read(32'd3, rb);

    // Chained save 0x20..0x2F, re-raising sd_wr at each ack fall.
    for (int i = 0; i < 256; i++) buf_ram[i] = 16'($urandom);
    @(negedge clk_sys);
    for (int s = 0; s < 16; s++) begin
      wb = wr_a.size();
      xfer(1'b1, 32'h20 + 32'(s), lat, ackc);
      chk("chain_acc_lat", lat, 1);
      check_write(32'h20 + 32'(s), wb);
      ref_write(32'h20 + 32'(s));
    end

    // Three-cycle memory stall on word 7 of lba 9.
    stall_addr = 24'h000907;
    stall_arm  = 3;
    @(negedge clk_sys);
    rb = rd_a.size();
    xfer(1'b0, 32'd9, lat, ackc);
    chk("stall_ack_cycles", ackc, 516);
    chk("stall_used", stall_used, 3);
    if (rd_c.size() >= rb + 9) begin
      chk("stall_gap7", rd_c[rb + 7] - rd_c[rb + 6], 5);
      chk("stall_gap8", rd_c[rb + 8] - rd_c[rb + 7], 2);
    end else begin
      chk("stall_pulses", rd_c.size() - rb, 256);
    end
    check_read(32'd9, rb);

    // Random mix of reads and writes with random memory waits.
    rand_wait = 1'b1;
    for (int t = 0; t < 10; t++) begin
      is_wr = 1'($urandom_range(0, 1));
      lba   = 32'($urandom_range(0, 15));
      @(negedge clk_sys);
      if (is_wr) begin
        for (int i = 0; i < 256; i++) buf_ram[i] = 16'($urandom);
        wb = wr_a.size();
        xfer(1'b1, lba, lat, ackc);
        check_write(lba, wb);
        ref_write(lba);
      end else begin
        rb = rd_a.size();
        xfer(1'b0, lba, lat, ackc);
        check_read(lba, rb);
      end
    end
    rand_wait = 1'b0;

    // Reset at word 100 of a read of lba 2.
    @(negedge clk_sys);
    rb = rd_a.size();
    sd_if.sd_lba = 32'd2;
    sd_if.sd_rd  = 1'b1;
    waitc = 0;
    while (!sd_if.sd_ack && waitc < 8) begin
      @(negedge clk_sys);
      waitc++;
    end
    sd_if.sd_rd = 1'b0;
    waitc = 0;
    while (rd_a.size() - rb < 100 && waitc < 2000) begin
      @(negedge clk_sys);
      waitc++;
    end
    chk("rst_mid_words", rd_a.size() - rb, 100);
    reset = 1'b1;
    #1;
    chk("rst_mid_ack", sd_if.sd_ack, 0);
    chk("rst_mid_mem_rd", mem_rd, 0);
    chk("rst_mid_buff_wr", sd_if.sd_buff_wr, 0);
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    rb = rd_a.size();
    xfer(1'b0, 32'd0, lat, ackc);
    chk("post_rst_ack_cycles", ackc, 513);
    check_read(32'd0, rb);
    chk("err_before_oor", err, 0);

    // Read of lba 64, one past the image.
    @(negedge clk_sys);
    rb = rd_a.size();
    mb = mr_a.size();
    xfer(1'b0, 32'd64, lat, ackc);
    chk("oor_ack_cycles", ackc, 513);
`ifdef SD_BLK_RESP_RANGE_CHECK_EN
    chk("oor_mem_rd_count", mr_a.size() - mb, 0);
    n = rd_a.size() - rb;
    chk("oor_rd_count", n, 256);
    for (int i = 0; i < ((n < 256) ? n : 256); i++) chk("oor_rd_data", rd_d[rb + i], 0);
    chk("oor_err", err, 1);
`else
    n = mr_a.size() - mb;
    chk("oor_mem_rd_count", n, 256);
    for (int i = 0; i < ((n < 256) ? n : 256); i++) chk("oor_mem_addr", mr_a[mb + i], 32'h4000 + 32'(i));
    check_read(32'd64, rb);
    chk("oor_err", err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
